// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Multicycle control FSM for the Harvard MIPS core. Each instruction is
// sequenced through FETCH / DECODE / EXEC / MEM / WB. Both memories are
// accessed through a req/ack handshake, so any number of wait states is
// tolerated, bounded by an optional timeout. The block also detects illegal
// opcodes, supports HALT, and counts retired instructions.
//
// Ports:
//   clk, reset_n          clock (rising edge) and asynchronous active-low reset
//   opcode, funct         instruction fields from the IR (sampled in DECODE)
//   alu_zero              ALU result == 0, qualifies BEQ/BNE in EXEC
//   imem_ack, dmem_ack    memory handshake acknowledges
//   imem_req, dmem_req    memory requests; mem_read/mem_write qualify dmem_req
//   ir_write, pc_write    IR load strobe and PC update strobe
//   pc_src                0 pc+4, 1 branch target, 2 jump target, 3 rs
//   reg_write, reg_dst    regfile write enable / dest select (0 rt, 1 rd, 2 $31)
//   wb_src                0 ALU, 1 dmem rdata, 2 pc (link)
//   alu_src, alu_op       ALU operand B select and operation
//   halted, fault         terminal status; fault_code 1 illegal, 2 imem, 3 dmem
//   retired               count of completed instructions (wraps)
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int              OP_W        = 6,
    parameter int              FN_W        = 6,
    parameter logic [OP_W-1:0] HALT_OP     = 6'h3F,
    parameter int              MEM_TIMEOUT = 16,
    parameter int              CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [OP_W-1:0]  opcode,
    input  logic [FN_W-1:0]  funct,
    input  logic             alu_zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_src,
    output logic [1:0]       alu_src,
    output logic [3:0]       alu_op,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] retired
);

    // Opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'h03);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'h05);
    localparam logic [OP_W-1:0] OP_ADDIU = OP_W'(6'h09);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'h0A);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(6'h0B);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'h0C);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'h0D);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(6'h0E);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'h0F);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);

    // R-type funct codes
    localparam logic [FN_W-1:0] FN_JR    = FN_W'(6'h08);
    localparam logic [FN_W-1:0] FN_JALR  = FN_W'(6'h09);
    localparam logic [FN_W-1:0] FN_ADDU  = FN_W'(6'h21);
    localparam logic [FN_W-1:0] FN_SUBU  = FN_W'(6'h23);
    localparam logic [FN_W-1:0] FN_AND   = FN_W'(6'h24);
    localparam logic [FN_W-1:0] FN_OR    = FN_W'(6'h25);
    localparam logic [FN_W-1:0] FN_XOR   = FN_W'(6'h26);
    localparam logic [FN_W-1:0] FN_SLT   = FN_W'(6'h2A);
    localparam logic [FN_W-1:0] FN_SLTU  = FN_W'(6'h2B);

    // ALU operations
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_LUI  = 4'd7;

    // Fault codes
    localparam logic [1:0] FC_ILLEGAL = 2'd1;
    localparam logic [1:0] FC_IMEM    = 2'd2;
    localparam logic [1:0] FC_DMEM    = 2'd3;

    // The timeout counter only ever needs to reach MEM_TIMEOUT-1.
    localparam int              TMO_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit              TMO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_FAULT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [OP_W-1:0]   r_op_q;
    logic [FN_W-1:0]   r_fn_q;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [CNT_W-1:0]  r_retired;
    logic [1:0]        r_fault_code;
    logic [1:0]        w_fault_code_next;
    logic              w_tmo_hit;
    logic              w_retire;
    logic              w_rtype;

    // ------------------------------------------------------------------
    // Instruction classification
    // ------------------------------------------------------------------
    function automatic logic is_r_alu(input logic [FN_W-1:0] fn);
        return (fn == FN_ADDU) || (fn == FN_SUBU) || (fn == FN_AND) ||
               (fn == FN_OR)   || (fn == FN_XOR)  || (fn == FN_SLT) ||
               (fn == FN_SLTU);
    endfunction

    function automatic logic is_i_alu(input logic [OP_W-1:0] op);
        return (op == OP_ADDIU) || (op == OP_SLTI) || (op == OP_SLTIU) ||
               (op == OP_ANDI)  || (op == OP_ORI)  || (op == OP_XORI)  ||
               (op == OP_LUI);
    endfunction

    function automatic logic is_supported(input logic [OP_W-1:0] op,
                                          input logic [FN_W-1:0] fn);
        if (op == OP_RTYPE) begin
            return is_r_alu(fn) || (fn == FN_JR) || (fn == FN_JALR);
        end
        return is_i_alu(op) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) || (op == OP_JAL);
    endfunction

    function automatic logic [3:0] alu_op_of(input logic [OP_W-1:0] op,
                                             input logic [FN_W-1:0] fn);
        logic [3:0] v;
        v = ALU_ADD;
        if (op == OP_RTYPE) begin
            case (fn)
                FN_SUBU: v = ALU_SUB;
                FN_AND:  v = ALU_AND;
                FN_OR:   v = ALU_OR;
                FN_XOR:  v = ALU_XOR;
                FN_SLT:  v = ALU_SLT;
                FN_SLTU: v = ALU_SLTU;
                default: v = ALU_ADD;
            endcase
        end else begin
            case (op)
                OP_SLTI:         v = ALU_SLT;
                OP_SLTIU:        v = ALU_SLTU;
                OP_ANDI:         v = ALU_AND;
                OP_ORI:          v = ALU_OR;
                OP_XORI:         v = ALU_XOR;
                OP_LUI:          v = ALU_LUI;
                OP_BEQ, OP_BNE:  v = ALU_SUB;
                default:         v = ALU_ADD;
            endcase
        end
        return v;
    endfunction

    // Logic immediates are zero-extended; every other immediate is sign-extended.
    function automatic logic [1:0] alu_src_of(input logic [OP_W-1:0] op);
        logic [1:0] v;
        v = 2'd0;
        case (op)
            OP_ANDI, OP_ORI, OP_XORI:                          v = 2'd2;
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LUI, OP_LW, OP_SW: v = 2'd1;
            default:                                           v = 2'd0;
        endcase
        return v;
    endfunction

    assign w_rtype   = (r_op_q == OP_RTYPE);
    assign w_tmo_hit = TMO_EN && (r_tmo_cnt == TMO_LAST);
    assign w_retire  = (r_state == S_WB) ||
                       (((r_state == S_EXEC) || (r_state == S_MEM)) && (w_next == S_FETCH));
    assign retired   = r_retired;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next            = r_state;
        w_fault_code_next = r_fault_code;
        case (r_state)
            S_START: w_next = S_FETCH;
            S_FETCH: begin
                // An ack in the threshold cycle takes priority over the timeout.
                if (imem_ack) begin
                    w_next = S_DECODE;
                end else if (w_tmo_hit) begin
                    w_next            = S_FAULT;
                    w_fault_code_next = FC_IMEM;
                end
            end
            S_DECODE: begin
                // Decision is made on the live IR fields; op_q/fn_q load on the same edge.
                if (opcode == HALT_OP) begin
                    w_next = S_HALT;
                end else if (!is_supported(opcode, funct)) begin
                    w_next            = S_FAULT;
                    w_fault_code_next = FC_ILLEGAL;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_rtype ? is_r_alu(r_fn_q) : is_i_alu(r_op_q)) begin
                    w_next = S_WB;
                end else if ((r_op_q == OP_LW) || (r_op_q == OP_SW)) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    w_next = (r_op_q == OP_LW) ? S_WB : S_FETCH;
                end else if (w_tmo_hit) begin
                    w_next            = S_FAULT;
                    w_fault_code_next = FC_DMEM;
                end
            end
            S_WB:    w_next = S_FETCH;
            S_HALT:  w_next = S_HALT;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_START;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore, except the ack-qualified FETCH strobes and the
    // alu_zero-qualified branch PC write)
    // ------------------------------------------------------------------
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        reg_write  = 1'b0;
        reg_dst    = 2'd0;
        wb_src     = 2'd0;
        alu_src    = 2'd0;
        alu_op     = ALU_ADD;
        halted     = 1'b0;
        fault      = 1'b0;
        fault_code = 2'd0;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ack;
                pc_write = imem_ack;
                pc_src   = 2'd0;
            end
            S_EXEC: begin
                alu_op  = alu_op_of(r_op_q, r_fn_q);
                alu_src = alu_src_of(r_op_q);
                if (w_rtype) begin
                    if ((r_fn_q == FN_JR) || (r_fn_q == FN_JALR)) begin
                        pc_write = 1'b1;
                        pc_src   = 2'd3;
                    end
                    // Link value is the PC already advanced during FETCH.
                    if (r_fn_q == FN_JALR) begin
                        reg_write = 1'b1;
                        reg_dst   = 2'd1;
                        wb_src    = 2'd2;
                    end
                end else begin
                    case (r_op_q)
                        OP_BEQ: begin
                            pc_write = alu_zero;
                            pc_src   = 2'd1;
                        end
                        OP_BNE: begin
                            pc_write = !alu_zero;
                            pc_src   = 2'd1;
                        end
                        OP_J: begin
                            pc_write = 1'b1;
                            pc_src   = 2'd2;
                        end
                        OP_JAL: begin
                            pc_write  = 1'b1;
                            pc_src    = 2'd2;
                            reg_write = 1'b1;
                            reg_dst   = 2'd2;
                            wb_src    = 2'd2;
                        end
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                // Address operands held stable for the whole handshake.
                dmem_req  = 1'b1;
                mem_read  = (r_op_q == OP_LW);
                mem_write = (r_op_q == OP_SW);
                alu_src   = 2'd1;
                alu_op    = ALU_ADD;
            end
            S_WB: begin
                reg_write = 1'b1;
                if (r_op_q == OP_LW) begin
                    wb_src  = 2'd1;
                    reg_dst = 2'd0;
                end else if (w_rtype) begin
                    wb_src  = 2'd0;
                    reg_dst = 2'd1;
                end else begin
                    wb_src  = 2'd0;
                    reg_dst = 2'd0;
                end
            end
            S_HALT: halted = 1'b1;
            S_FAULT: begin
                fault      = 1'b1;
                fault_code = r_fault_code;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // State, latched instruction fields, timeout, retired counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_START;
            r_op_q       <= '0;
            r_fn_q       <= '0;
            r_tmo_cnt    <= '0;
            r_retired    <= '0;
            r_fault_code <= '0;
        end else begin
            r_state      <= w_next;
            r_fault_code <= w_fault_code_next;
            if (r_state == S_DECODE) begin
                r_op_q <= opcode;
                r_fn_q <= funct;
            end
            // Any state change clears the counter, so it is zero on entry to
            // FETCH and MEM; it only advances while a request is left unacked.
            if (w_next != r_state) begin
                r_tmo_cnt <= '0;
            end else if (TMO_EN && ((r_state == S_FETCH) || (r_state == S_MEM))) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Self-checking bench for multicycle_control. Each instruction is described by
// a reference entry (expected EXEC controls, whether it has MEM and WB phases
// and what WB writes) derived from the instruction set table; the bench walks
// the instruction through its phases with randomized memory wait states and
// compares the controls seen in every cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int OP_W  = 6;
    localparam int FN_W  = 6;
    localparam int CNT_W = 32;
    localparam int TMO   = 4;

    localparam int K_RALU = 0;
    localparam int K_IALU = 1;
    localparam int K_LW   = 2;
    localparam int K_SW   = 3;
    localparam int K_BEQ  = 4;
    localparam int K_BNE  = 5;
    localparam int K_J    = 6;
    localparam int K_JAL  = 7;
    localparam int K_JR   = 8;
    localparam int K_JALR = 9;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [OP_W-1:0]  opcode = '0;
    logic [FN_W-1:0]  funct = '0;
    logic             alu_zero = 1'b0;
    logic             imem_ack = 1'b0;
    logic             dmem_ack = 1'b0;
    logic             imem_req, dmem_req, mem_read, mem_write, ir_write, pc_write;
    logic [1:0]       pc_src, reg_dst, wb_src, alu_src, fault_code;
    logic             reg_write, halted, fault;
    logic [3:0]       alu_op;
    logic [CNT_W-1:0] retired;

    multicycle_control #(
        .OP_W(OP_W), .FN_W(FN_W), .HALT_OP(6'h3F), .MEM_TIMEOUT(TMO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
        .wb_src(wb_src), .alu_src(alu_src), .alu_op(alu_op), .halted(halted),
        .fault(fault), .fault_code(fault_code), .retired(retired)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [CNT_W-1:0] exp_retired = '0;

    // ISA reference tables
    logic [5:0] r_fn     [7] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B};
    logic [3:0] r_aluop  [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    logic [5:0] i_opc    [7] = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    logic [3:0] i_aluop  [7] = '{4'd0, 4'd5, 4'd6, 4'd2, 4'd3, 4'd4, 4'd7};
    logic [1:0] i_src    [7] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1};

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [15:0] exec;
        logic        has_mem;
        logic        is_lw;
        logic        has_wb;
        logic [1:0]  wb_dst;
        logic [1:0]  wb_src;
    } exp_t;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [22:0] all_outs();
        return {imem_req, dmem_req, mem_read, mem_write, ir_write, pc_write, pc_src,
                reg_write, reg_dst, wb_src, alu_src, alu_op, halted, fault, fault_code};
    endfunction

    // Expected EXEC controls: {imem_req, dmem_req, pc_write, pc_src, reg_write,
    // reg_dst, wb_src, alu_src, alu_op}
    function automatic logic [15:0] pk(input logic pcw, input logic [1:0] pcs,
                                       input logic rw, input logic [1:0] rd,
                                       input logic [1:0] ws, input logic [1:0] as,
                                       input logic [3:0] ao);
        return {1'b0, 1'b0, pcw, pcs, rw, rd, ws, as, ao};
    endfunction

    function automatic exp_t model(input int kind, input int idx, input logic zero);
        exp_t e;
        e    = '0;
        e.fn = 6'($urandom);   // funct is don't-care outside R-type
        case (kind)
            K_RALU: begin
                e.op = 6'h00; e.fn = r_fn[idx];
                e.exec = pk(0, 0, 0, 0, 0, 0, r_aluop[idx]);
                e.has_wb = 1; e.wb_dst = 1; e.wb_src = 0;
            end
            K_IALU: begin
                e.op = i_opc[idx];
                e.exec = pk(0, 0, 0, 0, 0, i_src[idx], i_aluop[idx]);
                e.has_wb = 1; e.wb_dst = 0; e.wb_src = 0;
            end
            K_LW: begin
                e.op = 6'h23; e.exec = pk(0, 0, 0, 0, 0, 1, 0);
                e.has_mem = 1; e.is_lw = 1; e.has_wb = 1; e.wb_dst = 0; e.wb_src = 1;
            end
            K_SW: begin
                e.op = 6'h2B; e.exec = pk(0, 0, 0, 0, 0, 1, 0);
                e.has_mem = 1;
            end
            K_BEQ:  begin e.op = 6'h04; e.exec = pk(zero,  1, 0, 0, 0, 0, 1); end
            K_BNE:  begin e.op = 6'h05; e.exec = pk(!zero, 1, 0, 0, 0, 0, 1); end
            K_J:    begin e.op = 6'h02; e.exec = pk(1, 2, 0, 0, 0, 0, 0); end
            K_JAL:  begin e.op = 6'h03; e.exec = pk(1, 2, 1, 2, 2, 0, 0); end
            K_JR:   begin e.op = 6'h00; e.fn = 6'h08; e.exec = pk(1, 3, 0, 0, 0, 0, 0); end
            default: begin e.op = 6'h00; e.fn = 6'h09; e.exec = pk(1, 3, 1, 1, 2, 0, 0); end
        endcase
        return e;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1;
        chk_val("rst_outs", all_outs(), 0);
        chk_val("rst_retired", retired, 0);
        tick();
        reset_n = 1'b1;
        #1;
        chk_val("start_outs", all_outs(), 0);
        tick();
        exp_retired = '0;
    endtask

    // FETCH (with iwait unacked cycles) then DECODE of (op, fn).
    task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn, input int iwait);
        #1;
        chk_val("retired", retired, exp_retired);
        for (int i = 0; i <= iwait; i++) begin
            imem_ack = (i == iwait);
            #1;
            chk_val("fetch", {imem_req, ir_write, pc_write, pc_src, dmem_req, reg_write},
                    {1'b1, imem_ack, imem_ack, 2'd0, 1'b0, 1'b0});
            tick();
        end
        imem_ack = 1'b0;
        opcode   = op;
        funct    = fn;
        #1;
        chk_val("decode", all_outs(), 0);
        tick();
    endtask

    task automatic run_instr(input int kind, input int idx, input logic zero,
                             input int iwait, input int dwait);
        exp_t e;
        e = model(kind, idx, zero);
        fetch_decode(e.op, e.fn, iwait);
        // IR inputs are scrambled from here on: the FSM must use its latched copy.
        opcode   = 6'($urandom);
        funct    = 6'($urandom);
        alu_zero = zero;
        #1;
        chk_val("exec", {imem_req, dmem_req, pc_write, pc_src, reg_write, reg_dst,
                         wb_src, alu_src, alu_op}, e.exec);
        tick();
        if (e.has_mem) begin
            for (int i = 0; i <= dwait; i++) begin
                dmem_ack = (i == dwait);
                #1;
                chk_val("mem", {dmem_req, mem_read, mem_write, alu_src, alu_op, reg_write, imem_req},
                        {1'b1, e.is_lw, !e.is_lw, 2'd1, 4'd0, 1'b0, 1'b0});
                tick();
            end
            dmem_ack = 1'b0;
        end
        if (e.has_wb) begin
            #1;
            chk_val("wb", {reg_write, reg_dst, wb_src, imem_req, pc_write},
                    {1'b1, e.wb_dst, e.wb_src, 2'b00});
            tick();
        end
        exp_retired = exp_retired + 1;
    endtask

    initial begin
        tick();
        do_reset();

        // Directed sequences
        run_instr(K_IALU, 0, 1'b0, 0, 0);   // ADDIU
        run_instr(K_RALU, 0, 1'b0, 0, 0);   // ADDU
        #1;
        chk_val("retired_two", retired, 2);
        tick();
        // The extra FETCH cycle above is an unacked wait; continue from here.
        run_instr(K_LW,  0, 1'b0, 0, 3);
        run_instr(K_BEQ, 0, 1'b1, 0, 0);
        run_instr(K_BNE, 0, 1'b1, 0, 0);
        run_instr(K_JAL, 0, 1'b0, 0, 0);
        run_instr(K_JR,  0, 1'b0, 0, 0);

        // Randomized instruction stream with wait states inside the timeout window
        for (int n = 0; n < 80; n++) begin
            run_instr(int'($urandom_range(0, 9)), int'($urandom_range(0, 6)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)));
        end

        // Reset asserted in the middle of a MEM handshake
        fetch_decode(6'h23, 6'($urandom), 0);
        tick();                               // EXEC
        dmem_ack = 1'b0;
        #1;
        chk_val("mid_mem_req", dmem_req, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_val("mid_rst_outs", all_outs(), 0);
        chk_val("mid_rst_retired", retired, 0);
        tick();
        reset_n = 1'b1;
        #1;
        chk_val("mid_rst_start", all_outs(), 0);
        tick();
        #1;
        chk_val("mid_rst_fetch", imem_req, 1);
        tick();
        do_reset();

        // Instruction fetch timeout: no ack for TMO cycles
        for (int i = 0; i < TMO; i++) begin
            #1;
            chk_val("imem_wait", {imem_req, fault}, 2'b10);
            tick();
        end
        #1;
        chk_val("imem_tmo", {fault, fault_code, imem_req}, {1'b1, 2'd2, 1'b0});
        tick();
        #1;
        chk_val("imem_tmo_sticky", {fault, fault_code, imem_req}, {1'b1, 2'd2, 1'b0});
        do_reset();

        // Ack in the threshold cycle of both handshakes: no fault
        run_instr(K_SW, 0, 1'b0, TMO - 1, TMO - 1);
        #1;
        chk_val("ack_at_limit", {fault, imem_req}, 2'b01);
        do_reset();

        // Data memory timeout
        fetch_decode(6'h23, 6'h00, 0);
        tick();                               // EXEC
        for (int i = 0; i < TMO; i++) begin
            #1;
            chk_val("dmem_wait", {dmem_req, fault}, 2'b10);
            tick();
        end
        #1;
        chk_val("dmem_tmo", {fault, fault_code, dmem_req}, {1'b1, 2'd3, 1'b0});
        do_reset();

        // Illegal opcode
        fetch_decode(6'h3E, 6'h00, 0);
        #1;
        chk_val("illegal_op", {fault, fault_code, imem_req, halted}, {1'b1, 2'd1, 1'b0, 1'b0});
        do_reset();

        // Illegal funct under R-type
        fetch_decode(6'h00, 6'h00, 0);
        #1;
        chk_val("illegal_fn", {fault, fault_code, imem_req}, {1'b1, 2'd1, 1'b0});
        do_reset();

        // HALT stops the core and does not retire
        run_instr(K_IALU, 3, 1'b0, 0, 0);
        fetch_decode(6'h3F, 6'($urandom), 0);
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1;
            #1;
            chk_val("halt", {halted, imem_req, fault, ir_write}, 4'b1000);
            chk_val("halt_retired", retired, exp_retired);
            tick();
        end
        imem_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
